// File: rtl/uart_link_pkg.sv
// uart_link_pkg: FSM state encoding, UART command codes and bus widths shared by the link arbiter.
package uart_link_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  typedef enum logic [2:0] {
    UART_CMD_NOP    = 3'd0,
    UART_CMD_TX     = 3'd1,
    UART_CMD_RX     = 3'd2,
    UART_CMD_BAUD   = 3'd3,
    UART_CMD_STATUS = 3'd4
  } uart_cmd_t;
  localparam int UART_CMD_W  = 3;
  localparam int UART_DATA_W = 32;
  localparam int UART_BYTE_W = 8;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector; first set request at or after the pointer, wrapping.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);
  always_comb begin
    o_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (i_req[PTR_W'((int'(i_ptr) + k) % N_REQ)]) o_idx = PTR_W'((int'(i_ptr) + k) % N_REQ);
    o_any = |i_req;
    o_gnt = '0;
    o_gnt[o_idx] = o_any;
  end
endmodule

// File: rtl/uart_link_arbiter.sv
// uart_link_arbiter: round-robin sharing of one UART command port between N_REQ requesters.
// Optional watchdog on the write-back wait is enabled by defining UART_LINK_ARB_TIMEOUT_EN.
module uart_link_arbiter
  import uart_link_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int PTR_W       = $clog2(N_REQ),
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic [N_REQ-1:0]              i_req,
  input  logic [UART_CMD_W*N_REQ-1:0]   i_req_cmd,
  input  logic [UART_DATA_W*N_REQ-1:0]  i_req_data,
  output logic [N_REQ-1:0]              o_gnt,
  output logic [N_REQ-1:0]              o_rsp_valid,
  output logic [UART_BYTE_W-1:0]        o_rsp_data,
  output logic                          o_rsp_err,
  output logic                          o_busy,
  output logic [UART_CMD_W-1:0]         o_uart_instruction,
  output logic [UART_DATA_W-1:0]        o_uart_write_value,
  input  logic                          i_uart_done,
  input  logic [UART_BYTE_W-1:0]        i_uart_rx_data
);
  state_t                 r_state, w_next;
  logic [PTR_W-1:0]       r_ptr, r_owner, w_idx;
  logic [N_REQ-1:0]       w_onehot;
  logic                   w_any, w_timeout, w_finish;
  logic [UART_CMD_W-1:0]  r_cmd, r_instr;
  logic [UART_DATA_W-1:0] r_data, r_wval;
  logic [UART_BYTE_W-1:0] r_rsp_data;
  logic [N_REQ-1:0]       r_gnt, r_rsp_valid;

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .i_req(i_req), .i_ptr(r_ptr), .o_gnt(w_onehot), .o_idx(w_idx), .o_any(w_any)
  );

  assign w_finish = i_uart_done || w_timeout;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_any ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = w_finish ? RESP : WAIT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_cmd       <= UART_CMD_NOP;
      r_data      <= '0;
      r_instr     <= UART_CMD_NOP;
      r_wval      <= '0;
      r_rsp_data  <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
    end else begin
      r_state     <= w_next;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      case (r_state)
        IDLE: if (w_any) begin
          r_owner <= w_idx;
          r_ptr   <= (int'(w_idx) == N_REQ - 1) ? '0 : w_idx + 1'b1;
          r_gnt   <= w_onehot;
          r_cmd   <= i_req_cmd[w_idx*UART_CMD_W +: UART_CMD_W];
          r_data  <= i_req_data[w_idx*UART_DATA_W +: UART_DATA_W];
        end
        ISSUE: begin
          r_instr <= r_cmd;
          r_wval  <= r_data;
        end
        WAIT: if (w_finish) begin
          r_rsp_data           <= i_uart_done ? i_uart_rx_data : 8'hFF;
          r_rsp_valid[r_owner] <= 1'b1;
          r_instr              <= UART_CMD_NOP;
        end
        default: ;
      endcase
    end
  end

`ifdef UART_LINK_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  logic [WD_W-1:0] r_wdog;
  logic            r_rsp_err;
  assign w_timeout = r_wdog == WD_W'(TIMEOUT_CYC - 1);
  // counter sits at zero outside WAIT, so it is already cleared on entry
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wdog    <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_wdog <= (r_state == WAIT) ? r_wdog + 1'b1 : '0;
      if (r_state == WAIT && w_finish) r_rsp_err <= !i_uart_done;
    end
  end
  assign o_rsp_err = r_rsp_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYC != 0;
  assign w_timeout        = 1'b0;
  assign o_rsp_err        = 1'b0;
`endif

  assign o_gnt              = r_gnt;
  assign o_rsp_valid        = r_rsp_valid;
  assign o_rsp_data         = r_rsp_data;
  assign o_busy             = r_state != IDLE;
  assign o_uart_instruction = r_instr;
  assign o_uart_write_value = r_wval;
endmodule

// File: tb/tb_uart_link_arbiter.sv
// tb_uart_link_arbiter: directed and randomized transactions checked against a round-robin transaction model.
module tb_uart_link_arbiter;
  localparam int N = 2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [2:0]  cmd_v [N];
  logic [31:0] data_v [N];
  logic [5:0]  req_cmd;
  logic [63:0] req_data;
  logic [1:0]  gnt, rsp_valid;
  logic [7:0]  rsp_data, rx_data = '0;
  logic        rsp_err, busy, done = 1'b0;
  logic [2:0]  instr;
  logic [31:0] wval;
  int          n_cmp = 0, n_fail = 0, m_ptr = 0;

  assign req_cmd  = {cmd_v[1], cmd_v[0]};
  assign req_data = {data_v[1], data_v[0]};

  uart_link_arbiter #(.N_REQ(N), .TIMEOUT_CYC(16)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_req(req), .i_req_cmd(req_cmd), .i_req_data(req_data),
    .o_gnt(gnt), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_busy(busy),
    .o_uart_instruction(instr), .o_uart_write_value(wval), .i_uart_done(done), .i_uart_rx_data(rx_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] rq, input int p);
    for (int k = 0; k < N; k++) if (rq[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic randomize_reqs();
    for (int i = 0; i < N; i++) begin
      cmd_v[i]  = 3'($urandom_range(0, 7));
      data_v[i] = $urandom;
    end
  endtask

  // One full transaction from IDLE; requester data is scrambled after grant to prove it was latched.
  task automatic run_txn(input logic [1:0] rq, input bit hold, input int wcyc, input logic [7:0] rx);
    int w;
    logic [2:0]  ecmd;
    logic [31:0] edata;
    req   = rq;
    w     = pick(rq, m_ptr);
    ecmd  = cmd_v[w];
    edata = data_v[w];
    @(negedge clk);
    check("gnt", 32'(gnt), 32'(1 << w));
    check("busy_issue", 32'(busy), 1);
    m_ptr = (w + 1) % N;
    if (!hold) req[w] = 1'b0;
    randomize_reqs();
    @(negedge clk);
    check("instr_wait", 32'(instr), 32'(ecmd));
    check("wval_wait", wval, edata);
    check("gnt_clear", 32'(gnt), 0);
    for (int i = 0; i < wcyc; i++) begin
      @(negedge clk);
      check("instr_hold", 32'(instr), 32'(ecmd));
      check("no_rsp_wait", 32'(rsp_valid), 0);
    end
    done    = 1'b1;
    rx_data = rx;
    @(negedge clk);
    done = 1'b0;
    check("rsp_valid", 32'(rsp_valid), 32'(1 << w));
    check("rsp_data", 32'(rsp_data), 32'(rx));
    check("rsp_err", 32'(rsp_err), 0);
    check("instr_nop", 32'(instr), 0);
    @(negedge clk);
    check("rsp_clear", 32'(rsp_valid), 0);
    check("busy_idle", 32'(busy), 0);
    check("rsp_data_held", 32'(rsp_data), 32'(rx));
  endtask

  initial begin
    randomize_reqs();
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_wval", wval, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req", 32'(busy), 0);

    cmd_v[0]  = 3'd2;
    data_v[0] = 32'hDEADBEEF;
    run_txn(2'b01, 1'b0, 4, 8'h5A);

    m_ptr = 1;
    for (int t = 0; t < 4; t++) run_txn(2'b11, 1'b1, t, 8'($urandom));
    req = '0;

    req = 2'b01;
    @(negedge clk);
    check("late_gnt0", 32'(gnt), 1);
    req = 2'b10;
    @(negedge clk);
    req = 2'b00;
    repeat (2) begin
      @(negedge clk);
      check("late_no_gnt", 32'(gnt), 0);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("late_rsp", 32'(rsp_valid), 1);
    repeat (2) begin
      @(negedge clk);
      check("late_busy", 32'(busy), 0);
      check("late_gnt_after", 32'(gnt), 0);
    end
    m_ptr = 1;

    done = 1'b1;
    @(negedge clk);
    check("stray_idle", 32'(busy), 0);
    req = 2'b01;
    cmd_v[0] = 3'd1;
    @(negedge clk);
    check("stray_gnt", 32'(gnt), 1);
    req = 2'b00;
    @(negedge clk);
    check("stray_issue_ignored", 32'(rsp_valid), 0);
    check("stray_instr", 32'(instr), 1);
    done = 1'b0;
    @(negedge clk);
    check("stray_still_wait", 32'(busy), 1);
    check("stray_no_rsp", 32'(rsp_valid), 0);
    done    = 1'b1;
    rx_data = 8'hC3;
    @(negedge clk);
    done = 1'b0;
    check("stray_rsp", 32'(rsp_valid), 1);
    check("stray_rsp_data", 32'(rsp_data), 32'hC3);
    @(negedge clk);
    m_ptr = 1;

    for (int t = 0; t < 8; t++) begin
      randomize_reqs();
      run_txn(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 4), 8'($urandom));
    end
    req = '0;
    @(negedge clk);

    req = 2'b01;
    @(negedge clk);
    check("rst_mid_gnt", 32'(gnt), 1);
    req = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_mid_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_instr", 32'(instr), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_rsp", 32'(rsp_valid), 0);
    done = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    done  = 1'b0;
    m_ptr = 0;
    repeat (2) begin
      @(negedge clk);
      check("rst_mid_no_rsp", 32'(rsp_valid), 0);
      check("rst_mid_idle", 32'(busy), 0);
    end
    randomize_reqs();
    run_txn(2'b11, 1'b0, 1, 8'h3C);
    req = '0;

`ifdef UART_LINK_ARB_TIMEOUT_EN
    req = 2'b01;
    @(negedge clk);
    check("to_gnt", 32'(gnt), 1);
    req = 2'b00;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      check("to_waiting", 32'(rsp_valid), 0);
    end
    @(negedge clk);
    check("to_rsp", 32'(rsp_valid), 1);
    check("to_err", 32'(rsp_err), 1);
    check("to_data", 32'(rsp_data), 32'hFF);
    @(negedge clk);
    m_ptr = 1;
    randomize_reqs();
    run_txn(2'b01, 1'b0, 15, 8'h77);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
